// File: rtl/imem_arb.sv
// Two-requester valid/ready arbiter for the shared combinational imem read port.
// Define IMEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module imem_arb #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [15:0]       conflict_cnt
);

  localparam int unsigned CNT_W = 16;

  logic              prio;
  logic              elig0, elig1, gnt0, gnt1, both;
  logic [ADDR_W-1:0] last_a, last_a_nxt;
  logic              rsp0_valid_nxt, rsp1_valid_nxt;
  logic [DATA_W-1:0] rsp0_data_nxt, rsp1_data_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  // Grant selection and combinational port outputs; nothing is granted during reset.
  always_comb begin
    elig0      = req0_valid && (!rsp0_valid || rsp0_ready) && !reset;
    elig1      = req1_valid && (!rsp1_valid || rsp1_ready) && !reset;
    both       = elig0 && elig1;
    gnt0       = elig0 && (!elig1 || !prio);
    gnt1       = elig1 && (!elig0 || prio);
    req0_ready = gnt0;
    req1_ready = gnt1;
    mem_a      = last_a;
    if (gnt0) begin
      mem_a = req0_addr;
    end else if (gnt1) begin
      mem_a = req1_addr;
    end
  end

  // Response slots: a consume empties the slot unless an accept refills it the same cycle.
  always_comb begin
    rsp0_valid_nxt = rsp0_valid && !rsp0_ready;
    rsp1_valid_nxt = rsp1_valid && !rsp1_ready;
    rsp0_data_nxt  = rsp0_data;
    rsp1_data_nxt  = rsp1_data;
    last_a_nxt     = mem_a;
    cnt_nxt        = conflict_cnt;
    if (gnt0) begin
      rsp0_valid_nxt = 1'b1;
      rsp0_data_nxt  = mem_rd;
    end
    if (gnt1) begin
      rsp1_valid_nxt = 1'b1;
      rsp1_data_nxt  = mem_rd;
    end
    if (both && (conflict_cnt != {CNT_W{1'b1}})) begin
      cnt_nxt = conflict_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_data    <= '0;
      rsp1_data    <= '0;
      last_a       <= '0;
      conflict_cnt <= '0;
    end else begin
      rsp0_valid   <= rsp0_valid_nxt;
      rsp1_valid   <= rsp1_valid_nxt;
      rsp0_data    <= rsp0_data_nxt;
      rsp1_data    <= rsp1_data_nxt;
      last_a       <= last_a_nxt;
      conflict_cnt <= cnt_nxt;
    end
  end

`ifdef IMEM_ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  logic prio_nxt;

  // Round-robin: the requester just served yields priority to the other one.
  always_comb begin
    prio_nxt = prio;
    if (gnt0) begin
      prio_nxt = 1'b1;
    end else if (gnt1) begin
      prio_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else begin
      prio <= prio_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_imem_arb.sv
// Directed self-checking bench for imem_arb with a 64-word combinational memory model.
// Honours IMEM_ARB_FIXED_PRIO_EN when computing contention expectations.
module tb_imem_arb;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
`ifdef IMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr, mem_a;
  logic              rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp0_data, rsp1_data, mem_rd;
  logic [15:0]       conflict_cnt;
  logic [DATA_W-1:0] mem [64];

  int n_checks = 0;
  int n_errors = 0;
  int accepts;

  always #5 clk = ~clk;

  imem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
    .mem_a(mem_a), .mem_rd(mem_rd), .conflict_cnt(conflict_cnt)
  );

  always_comb mem_rd = mem[mem_a];

  function automatic logic [31:0] word(input int a);
    return 32'h2002_0000 | 32'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr  = '0;   req1_addr  = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = word(i);
    idle_inputs();
    reset = 1'b1;

    // Reset state, and requests during reset are not accepted
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 6'd3; req1_addr = 6'd4;
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    tick();
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp0_data", rsp0_data, 32'd0);
    check("rst_rsp1_data", rsp1_data, 32'd0);
    check("rst_mem_a", 32'(mem_a), 32'd0);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);
    reset = 1'b0;
    idle_inputs();

    // Single read of word 5
    req0_valid = 1'b1; req0_addr = 6'd5;
    #1;
    check("single_ready0", 32'(req0_ready), 32'd1);
    check("single_ready1", 32'(req1_ready), 32'd0);
    check("single_mem_a", 32'(mem_a), 32'd5);
    tick();
    check("single_rsp_valid", 32'(rsp0_valid), 32'd1);
    check("single_rsp_data", rsp0_data, 32'h2002_0005);
    req0_valid = 1'b0;
    tick();
    check("single_consumed", 32'(rsp0_valid), 32'd0);

    // Contention from reset
    do_reset();
    req0_valid = 1'b1; req0_addr = 6'd10;
    req1_valid = 1'b1; req1_addr = 6'd20;
    for (int k = 0; k < 8; k++) begin
      logic e0;
      e0 = FIXED ? 1'b1 : ((k % 2) == 0);
      #1;
      check("cont_cnt", 32'(conflict_cnt), 32'(k));
      check("cont_ready0", 32'(req0_ready), 32'(e0));
      check("cont_ready1", 32'(req1_ready), 32'(!e0));
      check("cont_mem_a", 32'(mem_a), e0 ? 32'd10 : 32'd20);
      tick();
    end
    check("cont_rsp0_data", rsp0_data, word(10));

    // Backpressure on requester 0 while requester 1 proceeds
    do_reset();
    req0_valid = 1'b1; req0_addr = 6'd3; rsp0_ready = 1'b0;
    #1;
    check("bp_c0_ready0", 32'(req0_ready), 32'd1);
    check("bp_c0_mem_a", 32'(mem_a), 32'd3);
    tick();
    check("bp_c1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("bp_c1_rsp0_data", rsp0_data, word(3));
    req1_valid = 1'b1; req1_addr = 6'd7;
    #1;
    check("bp_c1_ready0", 32'(req0_ready), 32'd0);
    check("bp_c1_ready1", 32'(req1_ready), 32'd1);
    check("bp_c1_mem_a", 32'(mem_a), 32'd7);
    tick();
    check("bp_c2_rsp1_data", rsp1_data, word(7));
    check("bp_c2_rsp0_data", rsp0_data, word(3));
    req1_addr = 6'd8;
    #1;
    check("bp_c2_ready0", 32'(req0_ready), 32'd0);
    check("bp_c2_ready1", 32'(req1_ready), 32'd1);
    check("bp_c2_mem_a", 32'(mem_a), 32'd8);
    tick();
    check("bp_c3_rsp1_data", rsp1_data, word(8));
    req1_valid = 1'b0;
    #1;
    check("bp_c3_ready0", 32'(req0_ready), 32'd0);
    check("bp_c3_rsp0_data", rsp0_data, word(3));
    tick();
    check("bp_c4_ready0", 32'(req0_ready), 32'd0);
    check("bp_c4_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("bp_c4_rsp0_data", rsp0_data, word(3));
    tick();
    rsp0_ready = 1'b1; req0_addr = 6'd12;
    #1;
    check("bp_c5_ready0", 32'(req0_ready), 32'd1);
    check("bp_c5_cnt", 32'(conflict_cnt), 32'd0);
    tick();
    check("bp_refill_valid", 32'(rsp0_valid), 32'd1);
    check("bp_refill_data", rsp0_data, word(12));
    req0_valid = 1'b0;
    tick();
    check("bp_drain_valid", 32'(rsp0_valid), 32'd0);
    check("bp_drain_hold", rsp0_data, word(12));

    // Streaming 64 words back-to-back on requester 0
    do_reset();
    accepts = 0;
    req0_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      req0_addr = 6'(i);
      #1;
      check("stream_mem_a", 32'(mem_a), 32'(i));
      if (req0_ready) accepts++;
      if (i > 0) begin
        check("stream_rsp_valid", 32'(rsp0_valid), 32'd1);
        check("stream_rsp_data", rsp0_data, word(i - 1));
      end
      tick();
    end
    req0_valid = 1'b0;
    check("stream_accepts", 32'(accepts), 32'd64);
    check("stream_last", rsp0_data, word(63));

    // Reset mid-operation
    do_reset();
    req0_valid = 1'b1; req0_addr = 6'd4;
    #1;
    check("rmid_c0_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 6'd9; rsp1_ready = 1'b0;
    #1;
    check("rmid_c1_ready1", 32'(req1_ready), 32'd1);
    tick();
    check("rmid_c2_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("rmid_c2_rsp1_data", rsp1_data, word(9));
    reset = 1'b1; req1_valid = 1'b0;
    #1;
    check("rmid_c2_mem_a", 32'(mem_a), 32'd9);
    tick();
    reset = 1'b0;
    check("rmid_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rmid_rsp1_data", rsp1_data, 32'd0);
    check("rmid_mem_a", 32'(mem_a), 32'd0);
    check("rmid_cnt", 32'(conflict_cnt), 32'd0);
    req0_valid = 1'b1; req0_addr = 6'd1; rsp0_ready = 1'b1;
    req1_valid = 1'b1; req1_addr = 6'd2; rsp1_ready = 1'b1;
    #1;
    check("rmid_c3_ready0", 32'(req0_ready), 32'd1);
    tick();
    check("rmid_c4_cnt", 32'(conflict_cnt), 32'd1);
    reset = 1'b1;
    #1;
    check("rmid_c4_ready0", 32'(req0_ready), 32'd0);
    check("rmid_c4_ready1", 32'(req1_ready), 32'd0);
    tick();
    reset = 1'b0;
    check("rmid_c5_cnt", 32'(conflict_cnt), 32'd0);
    check("rmid_c5_rsp0_valid", 32'(rsp0_valid), 32'd0);
    #1;
    check("rmid_c5_prio_ready0", 32'(req0_ready), 32'd1);
    check("rmid_c5_prio_ready1", 32'(req1_ready), 32'd0);
    tick();
    idle_inputs();

    // Counter saturation under continuous contention
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = 6'd30; req1_addr = 6'd31;
    repeat (65534) tick();
    check("sat_fffe", 32'(conflict_cnt), 32'h0000_fffe);
    tick();
    check("sat_ffff", 32'(conflict_cnt), 32'h0000_ffff);
    repeat (4465) tick();
    check("sat_hold", 32'(conflict_cnt), 32'h0000_ffff);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_arb.md
# imem_arb

Two-requester arbiter that shares the single combinational read port of the 64-word instruction memory between the CPU fetch stage (requester 0) and a second reader (requester 1, the debug/trace port). It accepts valid/ready requests and grants one per cycle. It drives the memory word address and captures the returned word into a per-requester registered response slot with its own valid/ready handshake. It sits between the core/debug logic and `imem`; no other block drives the memory address.

## Interface

Parameters:
- `ADDR_W`, 6: word-address width; matches memory depth 2^ADDR_W.
- `DATA_W`, 32: instruction word width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req0_valid`, in, 1: requester 0 has an address to read.
- `req0_addr`, in, ADDR_W: word address for requester 0.
- `req0_ready`, out, 1: requester 0's request is accepted this cycle.
- `rsp0_valid`, out, 1: `rsp0_data` holds a returned word.
- `rsp0_data`, out, DATA_W: word read for requester 0.
- `rsp0_ready`, in, 1: requester 0 consumes the response.
- `req1_valid`, `req1_addr`, `req1_ready`, `rsp1_valid`, `rsp1_data`, `rsp1_ready`: same as the requester 0 ports, for requester 1.
- `mem_a`, out, ADDR_W: address to the memory port.
- `mem_rd`, in, DATA_W: combinational read data from memory.
- `conflict_cnt`, out, 16: saturating count of cycles in which both requesters were eligible.

## Operation

- Each requester has at most one outstanding response. A response is held in its slot until consumed.
- Requester i is eligible when `reqi_valid` is high and its slot is free this cycle: `!rspi_valid || rspi_ready`.
- Grant selection:
  - Exactly one requester eligible: it is granted.
  - Both eligible: the one named by priority pointer `prio` wins.
  - Neither eligible: no grant.
- `reqi_ready` is 1 only for the granted requester. Accept happens when `reqi_valid && reqi_ready`.
- On accept by requester i:
  - `mem_a` = `reqi_addr` combinationally in the same cycle.
  - At the edge: `rspi_data` <= `mem_rd`, `rspi_valid` <= 1, `last_a` <= `reqi_addr`.
- Response consumption:
  - `rspi_valid && rspi_ready` with no new accept for i: `rspi_valid` <= 0 and `rspi_data` holds its value.
  - Consume and accept in the same cycle: the slot is refilled and `rspi_valid` stays 1.
- `prio` update, round-robin: after a grant to i, `prio` <= the other requester. Without a grant, `prio` holds.
- With no grant, `mem_a` = `last_a`, so the address does not toggle.
- `conflict_cnt` increments each cycle both requesters are eligible and saturates at 16'hFFFF.
- Addresses are word indices. No alignment check; all 2^ADDR_W values are legal.
- The `ready` outputs depend combinationally on both `valid` inputs. Requesters must not make `valid` depend on `ready`.

## Timing

- Reset values: `rsp0_valid` = `rsp1_valid` = 0, `rsp0_data` = `rsp1_data` = 0, `prio` = 0 (requester 0 first), `last_a` = 0 (so `mem_a` = 0), `conflict_cnt` = 0.
- `req*_ready` is 0 while `reset` is high.
- Latency: accept in cycle N gives `rspi_valid` = 1 from cycle N+1.
- Throughput: one accept per cycle total. A single requester with `rsp_ready` held high sustains one word per cycle.
- Backpressure: while `rspi_valid` = 1 and `rspi_ready` = 0, `rspi_data` is stable and `reqi_ready` = 0. The other requester proceeds unaffected.
- Reset mid-operation: pending responses are discarded. Requests presented in the reset cycle are not accepted.

## Configuration

- `IMEM_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins when both are eligible. `prio` is removed (tied to 0). Requester 1 is served only when requester 0 is not eligible.
  - Undefined (default): round-robin as described above.
- `conflict_cnt` behaves identically in both builds.

## Test plan

- Single read: memory preloaded with word 5 = 32'h2002_0005. `req0_valid` = 1, `req0_addr` = 5 in cycle 1 -> `req0_ready` = 1 and `mem_a` = 5 in cycle 1; `rsp0_valid` = 1 and `rsp0_data` = 32'h2002_0005 in cycle 2.
- Contention: both requesters valid every cycle, both `rsp_ready` = 1, from reset -> grants alternate 0,1,0,1; `conflict_cnt` increments by 1 per cycle. With the macro defined: all grants go to 0 and requester 1 is never ready.
- Backpressure: requester 0 read of addr 3, then `rsp0_ready` = 0 for 4 cycles with `req0_valid` held -> `rsp0_data` stable, `req0_ready` = 0 throughout. Requester 1 reads addr 7 and addr 8 during the stall and is served normally.
- Streaming: requester 0 alone, addrs 0..63 back-to-back, `rsp0_ready` = 1 -> 64 accepts in 64 consecutive cycles; responses in order, each one cycle after its accept.
- Reset mid-op: `reset` asserted the cycle after requester 1 is accepted -> next cycle `rsp1_valid` = 0, `mem_a` = 0, `conflict_cnt` = 0, `prio` = 0.
- Saturation: force continuous contention for 70000 cycles -> `conflict_cnt` stops at 16'hFFFF.
